// File: rtl/seg_display_scanner.sv
// Four-digit common-anode seven-segment scanner with frame-aligned double buffering.
// Optional leading-zero suppression: define SEG_LZ_BLANK_EN.
module seg_display_scanner #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned CNT_W       = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   input  logic [3:0]  blank_mask,
   output logic [3:0]  anode,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame,
   output logic        pending
);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic             tick;
   logic             commit;
   logic             commit_q;

   logic [15:0] act_val, pnd_val;
   logic [3:0]  act_dp, pnd_dp;
   logic [3:0]  act_blank, pnd_blank;

   logic [3:0]  nib;
   logic [6:0]  glyph;
   logic [3:0]  lz;
   logic        dark;
   logic [3:0]  anode_d;
   logic [6:0]  seg_d;
   logic        dp_d;

   assign tick   = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign commit = tick && (idx == 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         idx       <= '0;
         commit_q  <= 1'b0;
         frame     <= 1'b0;
         pending   <= 1'b0;
         act_val   <= '0;
         act_dp    <= '0;
         act_blank <= '1;
         pnd_val   <= '0;
         pnd_dp    <= '0;
         pnd_blank <= '1;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= idx + 1'b1;
         // frame trails commit by two edges so it coincides with digit 0 reaching the pins
         commit_q <= commit;
         frame    <= commit_q;
         if (commit) begin
            pending <= 1'b0;
            if (load) begin
               act_val   <= value;
               act_dp    <= dp_mask;
               act_blank <= blank_mask;
            end else if (pending) begin
               act_val   <= pnd_val;
               act_dp    <= pnd_dp;
               act_blank <= pnd_blank;
            end
         end else if (load) begin
            pnd_val   <= value;
            pnd_dp    <= dp_mask;
            pnd_blank <= blank_mask;
            pending   <= 1'b1;
         end
      end
   end

   always_comb begin
      nib = '0;
      case (idx)
         2'd0: nib = act_val[3:0];
         2'd1: nib = act_val[7:4];
         2'd2: nib = act_val[11:8];
         2'd3: nib = act_val[15:12];
         default: nib = '0;
      endcase
   end

   always_comb begin
      glyph = 7'h7F;
      case (nib)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         4'hF: glyph = 7'h0E;
         default: glyph = 7'h7F;
      endcase
   end

   always_comb begin
      lz = '0;
`ifdef SEG_LZ_BLANK_EN
      lz[3] = (act_val[15:12] == 4'h0);
      lz[2] = lz[3] && (act_val[11:8] == 4'h0);
      lz[1] = lz[2] && (act_val[7:4] == 4'h0);
`endif
      dark    = act_blank[idx] | lz[idx];
      anode_d = ~(4'b0001 << idx);
      seg_d   = dark ? 7'h7F : glyph;
      dp_d    = dark ? 1'b1 : ~act_dp[idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         anode <= '1;
         seg   <= '1;
         dp    <= 1'b1;
      end else begin
         anode <= anode_d;
         seg   <= seg_d;
         dp    <= dp_d;
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner: a cycle-indexed reference model
// pushes expected pin states; a monitor pops and compares after each edge.
module tb_seg_display_scanner;

   localparam int unsigned RD = 4;
   localparam int unsigned CW = 3;
   localparam int unsigned FRAME_LEN = 4 * RD;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_mask = '0;
   logic [3:0]  blank_mask = '0;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;
   logic        pending;

   always #5 clk = ~clk;

   seg_display_scanner #(.REFRESH_DIV(RD), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
      .blank_mask(blank_mask), .anode(anode), .seg(seg), .dp(dp),
      .frame(frame), .pending(pending)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] sg;
      logic       d;
      logic       fr;
      logic       pd;
   } exp_t;

   exp_t sb[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic [15:0] a_val, p_val;
   logic [3:0]  a_dp, a_bl, p_dp, p_bl;
   bit          p_flag;
   int unsigned k;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      a_val = '0; a_dp = '0; a_bl = 4'hF;
      p_val = '0; p_dp = '0; p_bl = 4'hF;
      p_flag = 0;
      k = 0;
   endtask

   // Called at a negedge: drive inputs for the coming posedge, predict pins after it.
   task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] dm, input logic [3:0] bm);
      exp_t        e;
      int unsigned d;
      logic [3:0]  nib;
      bit          dark;
      load = ld; value = v; dp_mask = dm; blank_mask = bm;
      k++;
      d    = ((k - 1) / RD) % 4;
      nib  = 4'(a_val >> (4 * d));
      dark = a_bl[d];
`ifdef SEG_LZ_BLANK_EN
      if (d != 0 && (a_val >> (4 * d)) == 0) dark = 1;
`endif
      e.an = 4'hF;
      e.an[d] = 1'b0;
      e.sg = dark ? 7'h7F : glyph_tbl[nib];
      e.d  = dark ? 1'b1 : ~a_dp[d];
      e.fr = (k > 1) && ((k - 1) % FRAME_LEN == 0);
      if (k % FRAME_LEN == 0) begin
         if (ld) begin
            a_val = v; a_dp = dm; a_bl = bm;
         end else if (p_flag) begin
            a_val = p_val; a_dp = p_dp; a_bl = p_bl;
         end
         p_flag = 0;
      end else if (ld) begin
         p_val = v; p_dp = dm; p_bl = bm;
         p_flag = 1;
      end
      e.pd = p_flag;
      sb.push_back(e);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(0, '0, '0, '0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("anode", anode, e.an);
            check("seg", seg, e.sg);
            check("dp", dp, e.d);
            check("frame", frame, e.fr);
            check("pending", pending, e.pd);
         end
      end
   end

   initial begin : stim
      model_reset();
      #23;
      check("rst_anode", anode, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1);
      check("rst_pending", pending, 0);
      check("rst_frame", frame, 0);
      @(negedge clk);
      rst = 1'b1;

      idle(20);
      step(1, 16'h12AF, 4'h0, 4'h0);
      idle(40);
      step(1, 16'h3333, 4'h0, 4'h0);
      idle(40);
      while ((k + 1) % FRAME_LEN != 0) idle(1);
      step(1, 16'h0008, 4'b0001, 4'h0);
      idle(20);
      step(1, 16'h0005, 4'h0, 4'h0);
      idle(40);
      step(1, 16'h0000, 4'h0, 4'h0);
      idle(40);

      for (int unsigned i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0)
            step(1, 16'($urandom), 4'($urandom_range(15)),
                 ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0);
         else
            idle(1);
      end

      while (((k - 1) / RD) % 4 != 2) idle(1);
      step(1, 16'hBEEF, 4'h0, 4'h0);
      #2;
      rst = 1'b0;
      #1;
      check("async_anode", anode, 4'hF);
      check("async_seg", seg, 7'h7F);
      check("async_dp", dp, 1);
      check("async_pending", pending, 0);
      check("async_frame", frame, 0);
      @(negedge clk);
      model_reset();
      rst = 1'b1;
      idle(30);
      step(1, 16'h12AF, 4'b1010, 4'h0);
      idle(40);

      @(posedge clk);
      #2;
      check("queue_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
